// File: rtl/ascon_pack.sv
// Shared Ascon definitions: state type, round constants, S-box and linear layer.
package ascon_pack;

    localparam int RC_LEN = 12;

    // x0 is the most significant word, so {x0,x1,x2,x3,x4} is the flat 320-bit state.
    typedef logic [0:4][63:0] type_state;

    typedef enum logic {ST_IDLE, ST_RUN} fsm_e;

    localparam int ROT0_A = 19, ROT0_B = 28;
    localparam int ROT1_A = 61, ROT1_B = 39;
    localparam int ROT2_A = 1,  ROT2_B = 6;
    localparam int ROT3_A = 10, ROT3_B = 17;
    localparam int ROT4_A = 7,  ROT4_B = 41;

    function automatic logic [7:0] round_const(input logic [3:0] r);
        case (r)
            4'd0:    return 8'hf0;
            4'd1:    return 8'he1;
            4'd2:    return 8'hd2;
            4'd3:    return 8'hc3;
            4'd4:    return 8'hb4;
            4'd5:    return 8'ha5;
            4'd6:    return 8'h96;
            4'd7:    return 8'h87;
            4'd8:    return 8'h78;
            4'd9:    return 8'h69;
            4'd10:   return 8'h5a;
            4'd11:   return 8'h4b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Bit-sliced 5-bit S-box applied to all 64 columns at once.
    function automatic type_state sbox_layer(input type_state s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[0] ^ s[4];
        x4 = s[4] ^ s[3];
        x2 = s[2] ^ s[1];
        x1 = s[1];
        x3 = s[3];
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic type_state linear_layer(input type_state s);
        type_state o;
        o[0] = s[0] ^ ror64(s[0], ROT0_A) ^ ror64(s[0], ROT0_B);
        o[1] = s[1] ^ ror64(s[1], ROT1_A) ^ ror64(s[1], ROT1_B);
        o[2] = s[2] ^ ror64(s[2], ROT2_A) ^ ror64(s[2], ROT2_B);
        o[3] = s[3] ^ ror64(s[3], ROT3_A) ^ ror64(s[3], ROT3_B);
        o[4] = s[4] ^ ror64(s[4], ROT4_A) ^ ror64(s[4], ROT4_B);
        return o;
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round; bypasses the state when enable_i is low.
module ascon_round
    import ascon_pack::*;
(
    input  logic       enable_i,
    input  logic [3:0] round_i,
    input  type_state  state_i,
    output type_state  state_o
);

    type_state added;
    type_state subst;
    type_state diff;

    always_comb begin
        added          = state_i;
        added[2][7:0]  = state_i[2][7:0] ^ round_const(round_i);
        subst          = sbox_layer(added);
        diff           = linear_layer(subst);
        state_o        = enable_i ? diff : state_i;
    end

endmodule

// File: rtl/ascon_permutation_iter.sv
// Iterative Ascon p^a/p^b engine, UNROLL rounds per clock.
// Optional ASCON_PERM_ABORT_EN adds abort_i to cancel a running permutation.
module ascon_permutation_iter
    import ascon_pack::*;
#(
    parameter int UNROLL     = 1,
    parameter int MAX_ROUNDS = 12
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic [3:0] nb_rounds_i,
    input  type_state  state_i,
`ifdef ASCON_PERM_ABORT_EN
    input  logic       abort_i,
`endif
    output type_state  state_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    fsm_e       fsm_q;
    type_state  perm_q, perm_d;
    logic [4:0] cnt_q, cnt_d;
    logic       busy_q, done_q, error_q;
    logic       nb_ok;

    type_state  stage [UNROLL+1];

    assign stage[0] = perm_q;

    // Stage k handles round cnt_q+k; rounds past the end pass through untouched.
    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        logic [4:0] r_k;
        assign r_k = cnt_q + 5'(k);
        ascon_round u_round (
            .enable_i (r_k < 5'(MAX_ROUNDS)),
            .round_i  (r_k[3:0]),
            .state_i  (stage[k]),
            .state_o  (stage[k+1])
        );
    end

    assign perm_d = stage[UNROLL];
    assign cnt_d  = cnt_q + 5'(UNROLL);
    assign nb_ok  = (nb_rounds_i != 4'd0) && ({1'b0, nb_rounds_i} <= 5'(MAX_ROUNDS));

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= ST_IDLE;
            perm_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (fsm_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (nb_ok) begin
                            perm_q <= state_i;
                            cnt_q  <= 5'(MAX_ROUNDS) - {1'b0, nb_rounds_i};
                            busy_q <= 1'b1;
                            fsm_q  <= ST_RUN;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
`ifdef ASCON_PERM_ABORT_EN
                    if (abort_i) begin
                        fsm_q  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else
`endif
                    begin
                        perm_q <= perm_d;
                        cnt_q  <= cnt_d;
                        if (cnt_d >= 5'(MAX_ROUNDS)) begin
                            fsm_q  <= ST_IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign state_o = perm_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Bench: UNROLL=1 and UNROLL=4 instances share stimulus, checked against a table-driven Ascon model.
module tb_ascon_permutation_iter;

    logic         clk = 1'b0;
    logic         rstb = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   nb = 4'd0;
    logic [319:0] st_in = '0;
`ifdef ASCON_PERM_ABORT_EN
    logic         abort = 1'b0;
`endif
    logic [319:0] so1, so4;
    logic         busy1, done1, err1, busy4, done4, err4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ascon_permutation_iter #(.UNROLL(1)) u1 (
        .clock_i(clk), .resetb_i(rstb), .start_i(start), .nb_rounds_i(nb), .state_i(st_in),
`ifdef ASCON_PERM_ABORT_EN
        .abort_i(abort),
`endif
        .state_o(so1), .busy_o(busy1), .done_o(done1), .error_o(err1)
    );

    ascon_permutation_iter #(.UNROLL(4)) u4 (
        .clock_i(clk), .resetb_i(rstb), .start_i(start), .nb_rounds_i(nb), .state_i(st_in),
`ifdef ASCON_PERM_ABORT_EN
        .abort_i(abort),
`endif
        .state_o(so4), .busy_o(busy4), .done_o(done4), .error_o(err4)
    );

    // Ascon S-box as a lookup on column {x0,x1,x2,x3,x4}, x0 the MSB.
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] model(input logic [319:0] s, input int first, input int cnt);
        logic [63:0] x [5];
        logic [63:0] y [5];
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int r = first; r < first + cnt; r++) begin
            x[2] = x[2] ^ 64'((15 - r) * 16 + r);
            for (int b = 0; b < 64; b++) begin
                logic [4:0] v, o;
                v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o = SBOX[v];
                y[0][b] = o[4]; y[1][b] = o[3]; y[2][b] = o[2]; y[3][b] = o[1]; y[4][b] = o[0];
            end
            x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
            x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
            x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
            x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
            x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rnd();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input int nbr, input logic [319:0] src);
        @(negedge clk);
        start = 1'b1;
        nb    = 4'(nbr);
        st_in = src;
    endtask

    // Follows one permutation to completion on both instances and checks timing and result.
    task automatic track(input int nbr, input logic [319:0] src, input int poke,
                         input bit b2b, input int nb2, input logic [319:0] src2);
        int lat1 = -1, lat4 = -1, bz1 = 0, bz4 = 0;
        bit serr = 1'b0;
        logic [319:0] r1 = '0, r4 = '0, exp;
        exp = model(src, 12 - nbr, nbr);
        for (int c = 1; c <= 30 && (lat1 < 0 || lat4 < 0); c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy1) bz1++;
            if (busy4) bz4++;
            if (err1 || err4) serr = 1'b1;
            if (done4 && lat4 < 0) begin lat4 = c; r4 = so4; end
            if (done1 && lat1 < 0) begin
                lat1 = c;
                r1 = so1;
                if (b2b) begin start = 1'b1; nb = 4'(nb2); st_in = src2; end
            end
            if (c == poke) begin start = 1'b1; nb = 4'd6; st_in = rnd(); end
        end
        chk($sformatf("lat1_nb%0d", nbr), 320'(lat1), 320'(nbr + 1));
        chk($sformatf("lat4_nb%0d", nbr), 320'(lat4), 320'((nbr + 3) / 4 + 1));
        chk($sformatf("busy1_nb%0d", nbr), 320'(bz1), 320'(nbr));
        chk($sformatf("busy4_nb%0d", nbr), 320'(bz4), 320'((nbr + 3) / 4));
        chk($sformatf("res1_nb%0d", nbr), r1, exp);
        chk($sformatf("res4_nb%0d", nbr), r4, exp);
        chk($sformatf("noerr_nb%0d", nbr), 320'(serr), 320'(0));
    endtask

    task automatic bad_nb(input int nbr);
        logic [319:0] h1, h4;
        @(negedge clk);
        h1 = so1; h4 = so4;
        start = 1'b1;
        nb = 4'(nbr);
        st_in = rnd();
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("err_pulse_nb%0d", nbr), 320'({err1, err4, busy1, busy4, done1, done4}), 320'(6'b110000));
        chk($sformatf("err_hold1_nb%0d", nbr), so1, h1);
        chk($sformatf("err_hold4_nb%0d", nbr), so4, h4);
        @(negedge clk);
        chk($sformatf("err_clear_nb%0d", nbr), 320'({err1, err4, busy1, busy4}), 320'(0));
    endtask

    initial begin
        logic [319:0] a, b;
        int nbr, seen;

        @(negedge clk);
        chk("reset_state1", so1, '0);
        chk("reset_state4", so4, '0);
        chk("reset_flags", 320'({busy1, done1, err1, busy4, done4, err4}), 320'(0));
        rstb = 1'b1;

        a = {64'h80400c0600000000, 256'h0};
        launch(12, a);
        track(12, a, 2, 1'b0, 0, '0);

        a = rnd();
        launch(6, a);
        track(6, a, 0, 1'b0, 0, '0);

        launch(1, '0);
        track(1, '0, 0, 1'b0, 0, '0);

        bad_nb(0);
        bad_nb(13);
        bad_nb(15);

        a = rnd();
        b = rnd();
        launch(12, a);
        track(12, a, 0, 1'b1, 8, b);
        track(8, b, 0, 1'b0, 0, '0);

        for (int i = 0; i < 4; i++) begin
            nbr = $urandom_range(1, 12);
            a = rnd();
            launch(nbr, a);
            track(nbr, a, 0, 1'b0, 0, '0);
        end

        a = rnd();
        launch(12, a);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rstb = 1'b0;
        #1;
        chk("rst_mid_state1", so1, '0);
        chk("rst_mid_state4", so4, '0);
        chk("rst_mid_flags", 320'({busy1, done1, err1, busy4, done4, err4}), 320'(0));
        @(negedge clk);
        rstb = 1'b1;
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (done1 || done4 || busy1 || busy4) seen++;
        end
        chk("rst_mid_no_done", 320'(seen), 320'(0));

`ifdef ASCON_PERM_ABORT_EN
        a = rnd();
        launch(12, a);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_flags", 320'({busy1, done1, busy4, done4}), 320'(0));
        chk("abort_part1", so1, model(a, 0, 1));
        chk("abort_part4", so4, model(a, 0, 4));
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (done1 || done4 || busy1 || busy4) seen++;
        end
        chk("abort_no_done", 320'(seen), 320'(0));
        chk("abort_hold1", so1, model(a, 0, 1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ascon_permutation_iter.md
Name: ascon_permutation_iter

Overview:
- Iterative Ascon permutation engine for p^a/p^b: constant addition, substitution layer and linear diffusion applied for a programmable number of rounds.
- UNROLL rounds are evaluated per clock.
- Sits between the mode controller (init/absorb/squeeze/finalise FSM) and the 320-bit state register path.
- Replaces the per-round combinational datapath that needed external round sequencing.

Parameters:
- UNROLL, 1, rounds computed per clock; legal range 1..4.
- MAX_ROUNDS, 12, total round-constant table length; round index range 0..MAX_ROUNDS-1.

Ports:
- clock_i  in  1  system clock
- resetb_i  in  1  reset
- start_i  in  1  request: load state_i and run nb_rounds_i rounds
- nb_rounds_i  in  4  rounds to apply; legal 1..12 (6/8/12 in normal use)
- state_i  in  320 (type_state)  input state x0..x4
- state_o  out  320 (type_state)  permutation result; held until next accepted start
- busy_o  out  1  high while rounds are in progress
- done_o  out  1  one-cycle pulse when state_o is final
- error_o  out  1  one-cycle pulse: start_i with illegal nb_rounds_i ignored

Interface decision:
- One clock; reset is asynchronous and active-low (resetb_i).

Behaviour:
- FSM states IDLE, RUN.
- Reset (async, resetb_i low):
  - FSM=IDLE; state register, round counter, busy_o, done_o, error_o all 0.
  - state_o reads 0.
  - Reset mid-RUN aborts with no done_o.
- IDLE + start_i, nb_rounds_i in 1..12:
  - state register <= state_i; counter <= 12 - nb_rounds_i; FSM -> RUN; busy_o=1 from the next cycle.
- IDLE + start_i, nb_rounds_i = 0 or > 12:
  - Request ignored; error_o pulses the next cycle; stays IDLE; state_o unchanged.
- RUN, each cycle:
  - UNROLL cascaded round stages. Stage k uses round index r = counter + k.
  - Each stage is active only if r < 12; inactive stages pass the state through unchanged.
  - Active stage operations:
    - constant addition: x2[7:0] ^= round_constant[r]; all other bits unchanged;
    - 5-bit S-box across all 64 bit-slices;
    - linear diffusion: x0 ^ (x0>>>19) ^ (x0>>>28), x1 ^ (x1>>>61) ^ (x1>>>39), x2 ^ (x2>>>1) ^ (x2>>>6), x3 ^ (x3>>>10) ^ (x3>>>17), x4 ^ (x4>>>7) ^ (x4>>>41).
  - Counter <= counter + UNROLL.
  - Counter is 5 bits wide internally, so counter + UNROLL cannot wrap (max 11 + 4 = 15).
- Completion:
  - When the updated counter >= 12: FSM -> IDLE, busy_o -> 0, done_o pulses in that same cycle's registered output.
  - Latency from start_i to done_o is ceil(nb_rounds_i / UNROLL) + 1 cycles (load cycle + compute cycles).
- start_i while RUN: ignored, no error_o. The mode controller must wait for done_o.
- start_i in the same cycle done_o is high: accepted (FSM already IDLE), giving back-to-back permutations with no gap.
- state_o:
  - Driven directly from the state register.
  - Intermediate values are visible while busy_o=1 and are not valid.

Optional Feature:
- ASCON_PERM_ABORT_EN
- Defined:
  - Adds input port abort_i (1 bit).
  - abort_i high in RUN: FSM -> IDLE next cycle, busy_o -> 0, no done_o; state register holds the partial value.
  - abort_i in IDLE has no effect.
  - abort_i and start_i in the same IDLE cycle: start wins.
- Undefined: port absent; a permutation always runs to completion or reset.

Decomposition:
- ascon_pack (shared):
  - type_state (array of 5 × 64-bit words);
  - round_constant table [0..11] = f0,e1,d2,c3,b4,a5,96,87,78,69,5a,4b;
  - function/constant for the S-box;
  - rotate amounts.
- One sub-module: ascon_round. Purely combinational, one full round with enable_i (bypass when low) and round_i (4 bits). Instantiated UNROLL times in a generate loop.

Test Plan:
- UNROLL=1, nb_rounds_i=12, state_i = Ascon-128 IV state (x0=80400c0600000000, key=nonce=0) -> done_o exactly 13 cycles after start_i; state_o matches golden software p12; busy_o high 12 cycles.
- UNROLL=4, nb_rounds_i=6 -> done_o after 3 cycles; second compute cycle activates only rounds 10,11; state_o equals UNROLL=1 result for the same input.
- nb_rounds_i=1, state_i all zero -> only round 11 applied; after constant addition x2 = 000000000000004b; state_o matches golden single round.
- nb_rounds_i=0, then 13 -> error_o pulses each time, FSM stays IDLE, state_o unchanged; start_i pulsed during RUN -> ignored, result unaffected.
- Back-to-back: start_i asserted in the done_o cycle with nb_rounds_i=8 -> second done_o 9 cycles later, both results correct.
- resetb_i low during RUN cycle 3 -> all outputs 0 immediately (asynchronous); no done_o. With ASCON_PERM_ABORT_EN: abort_i in cycle 2 -> busy_o 0 next cycle, no done_o.
